com_fw_to_dut_arb: RTL and testbench

Parametrised firmware-to-DUT I/O arbiter, the successor of the fixed 4-firmware, 10-out/5-in DUT pin mux. Up to N_FW firmware IPs share one DUT pin set, with output and input IOB flops at the FPGA pins. Ownership changes go through a state machine that drives safe default pin levels for a programmable guard interval before the new owner takes over. It also flags illegal selections, keeps fixed-owner pins (clocks) on a dedicated firmware, and counts ownership switches.

---
 rtl/com_fw_to_dut_arb.sv | 167 ++++++++++++++++
 tb/tb_com_fw_to_dut_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/com_fw_to_dut_arb.sv
// Purpose : shares one DUT pin set between N_FW firmware channels, with a guarded ownership handover.
// Latency : fw_out -> dut_out 1 cycle (IOB flop); dut_in -> fw_in IN_SYNC_STAGES cycles; owner data lands GUARD_CYCLES+2 after the request edge.
// Backpress: none; requests are level-held, and the pins show safe defaults until the guard interval completes.
//
// Ports:
//   iob_clk, iob_rst_n      pin clock, async active-low reset
//   fw_dev_id_enable        one-hot owner request
//   fw_out / fw_in          per-channel pin bundles, channel c at [c*W +: W]
//   dut_out / dut_in        FPGA pins (output and input IOB flops)
//   sel_active, switch_busy current owner (one-hot) and guard indicator
//   sel_error, sel_error_clr sticky multi-hot request flag and its clear
//   switch_count            completed guard-to-active handovers, wrapping
module com_fw_to_dut_arb #(
    parameter int                     N_FW           = 4,
    parameter int                     N_OUT          = 10,
    parameter int                     N_IN           = 5,
    parameter logic [N_OUT-1:0]       OUT_DEFAULT    = 10'b0000010100,
    parameter logic [N_OUT-1:0]       FIXED_MASK     = 10'b0001100010,
    parameter logic [N_OUT*4-1:0]     FIXED_IDX      = 40'h0001100000,
    parameter int                     GUARD_CYCLES   = 16,
    parameter int                     IN_SYNC_STAGES = 2
) (
    input  logic                    iob_clk,
    input  logic                    iob_rst_n,
    input  logic [N_FW-1:0]         fw_dev_id_enable,
    input  logic [N_FW*N_OUT-1:0]   fw_out,
    output logic [N_FW*N_IN-1:0]    fw_in,
    output logic [N_OUT-1:0]        dut_out,
    input  logic [N_IN-1:0]         dut_in,
    output logic [N_FW-1:0]         sel_active,
    output logic                    switch_busy,
    output logic                    sel_error,
    input  logic                    sel_error_clr,
    output logic [15:0]             switch_count
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GUARD  = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    localparam int            GW     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] RELOAD = GW'(GUARD_CYCLES - 1);

    logic [N_FW-1:0] en_q;
    logic [1:0]      state_q, state_d;
    logic [N_FW-1:0] owner_q, owner_d;
    logic [N_FW-1:0] pending_q, pending_d;
    logic [GW-1:0]   guard_cnt_q, guard_cnt_d;
    logic [15:0]     count_q, count_d;
    logic            err_q, err_d;
    logic [N_OUT-1:0] dut_out_q, dut_out_d;
    logic [N_IN-1:0]  sync_q [IN_SYNC_STAGES];

    logic en_zero, en_multi, en_valid, is_active;

    // Clearing the lowest set bit leaves something only when two or more bits are set.
    assign en_zero   = (en_q == '0);
    assign en_multi  = |(en_q & (en_q - N_FW'(1)));
    assign en_valid  = !en_zero && !en_multi;
    assign is_active = (state_q == ST_ACTIVE);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        pending_d   = pending_q;
        guard_cnt_d = guard_cnt_q;
        count_d     = count_q;
        case (state_q)
            ST_IDLE: begin
                if (en_valid) begin
                    state_d     = ST_GUARD;
                    pending_d   = en_q;
                    guard_cnt_d = RELOAD;
                end
            end
            ST_GUARD: begin
                if (!en_valid) begin
                    state_d = ST_IDLE;
                end else if (en_q != pending_q) begin
                    // A different channel mid-guard restarts the full guard for it.
                    pending_d   = en_q;
                    guard_cnt_d = RELOAD;
                end else if (guard_cnt_q == '0) begin
                    state_d = ST_ACTIVE;
                    owner_d = pending_q;
                    count_d = count_q + 16'd1;
                end else begin
                    guard_cnt_d = guard_cnt_q - GW'(1);
                end
            end
            ST_ACTIVE: begin
                if (en_q == owner_q) begin
                    state_d = ST_ACTIVE;
                end else if (en_valid) begin
                    state_d     = ST_GUARD;
                    pending_d   = en_q;
                    guard_cnt_d = RELOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Set has priority over clear so a simultaneous error is never lost.
    assign err_d = en_multi ? 1'b1 : (sel_error_clr ? 1'b0 : err_q);

    // Per-pin mux feeding the output IOB flop. Fixed pins ignore the FSM so
    // clocks keep running through every handover.
    for (genvar i = 0; i < N_OUT; i++) begin : g_pin
        logic own_bit;
        logic fix_bit;
        always_comb begin
            own_bit = 1'b0;
            fix_bit = 1'b0;
            for (int c = 0; c < N_FW; c++) begin
                own_bit = own_bit | (owner_q[c] & fw_out[c*N_OUT + i]);
                if (FIXED_IDX[i*4 +: 4] == 4'(c)) begin
                    fix_bit = fw_out[c*N_OUT + i];
                end
            end
        end
        assign dut_out_d[i] = FIXED_MASK[i] ? fix_bit
                            : (is_active ? own_bit : OUT_DEFAULT[i]);
    end

    for (genvar c = 0; c < N_FW; c++) begin : g_fw_in
        assign fw_in[c*N_IN +: N_IN] = (is_active && owner_q[c]) ? sync_q[IN_SYNC_STAGES-1] : '0;
    end

    always_ff @(posedge iob_clk or negedge iob_rst_n) begin
        if (!iob_rst_n) begin
            en_q        <= '0;
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            pending_q   <= '0;
            guard_cnt_q <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            dut_out_q   <= OUT_DEFAULT;
            for (int s = 0; s < IN_SYNC_STAGES; s++) begin
                sync_q[s] <= '0;
            end
        end else begin
            en_q        <= fw_dev_id_enable;
            state_q     <= state_d;
            owner_q     <= owner_d;
            pending_q   <= pending_d;
            guard_cnt_q <= guard_cnt_d;
            count_q     <= count_d;
            err_q       <= err_d;
            dut_out_q   <= dut_out_d;
            sync_q[0]   <= dut_in;
            for (int s = 1; s < IN_SYNC_STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign dut_out      = dut_out_q;
    assign sel_active   = is_active ? owner_q : '0;
    assign switch_busy  = (state_q == ST_GUARD);
    assign sel_error    = err_q;
    assign switch_count = count_q;

endmodule

// File: tb/tb_com_fw_to_dut_arb.sv
`timescale 1ns/1ps
module tb_com_fw_to_dut_arb;

    localparam logic [9:0] DEF   = 10'h014;
    localparam logic [9:0] FMASK = 10'h062;
    localparam logic [9:0] FW0   = 10'h0C3;
    localparam logic [9:0] FW1   = 10'h3FF;
    localparam logic [9:0] FW2   = 10'h2A5;
    localparam logic [9:0] FW3   = 10'h13C;

    logic        iob_clk = 1'b0;
    logic        iob_rst_n;
    logic [3:0]  fw_dev_id_enable;
    logic [39:0] fw_out;
    logic [19:0] fw_in;
    logic [9:0]  dut_out;
    logic [4:0]  dut_in;
    logic [3:0]  sel_active;
    logic        switch_busy;
    logic        sel_error;
    logic        sel_error_clr;
    logic [15:0] switch_count;

    com_fw_to_dut_arb dut (
        .iob_clk          (iob_clk),
        .iob_rst_n        (iob_rst_n),
        .fw_dev_id_enable (fw_dev_id_enable),
        .fw_out           (fw_out),
        .fw_in            (fw_in),
        .dut_out          (dut_out),
        .dut_in           (dut_in),
        .sel_active       (sel_active),
        .switch_busy      (switch_busy),
        .sel_error        (sel_error),
        .sel_error_clr    (sel_error_clr),
        .switch_count     (switch_count)
    );

    always #5 iob_clk = ~iob_clk;

    int cyc = 0;
    always @(posedge iob_clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [9:0]  dout;
        logic [3:0]  sel;
        logic        busy;
        logic        err;
        logic [15:0] cnt;
        logic [19:0] fwin;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    // Expected pin levels: own < 0 means no owner (defaults). Pin 1 is fixed
    // to ch0, pins 5 and 6 (bxclk, bxclk_ana) are fixed to ch1.
    function automatic logic [9:0] pins(int own);
        logic [9:0] r;
        case (own)
            0:       r = FW0;
            1:       r = FW1;
            2:       r = FW2;
            3:       r = FW3;
            default: r = DEF;
        endcase
        return (r & ~FMASK) | (FW0 & 10'h002) | (FW1 & 10'h060);
    endfunction

    function automatic logic [19:0] fi(int ch, logic [4:0] v);
        return 20'(v) << (5 * ch);
    endfunction

    task automatic expect_range(string nm, int a, int b, logic [9:0] d, logic [3:0] s,
                                logic bz, logic er, logic [15:0] c, logic [19:0] f);
        exp_t e;
        for (int j = a; j <= b; j++) begin
            e.cyc = j; e.dout = d; e.sel = s; e.busy = bz; e.err = er;
            e.cnt = c; e.fwin = f; e.name = nm;
            sb.push_back(e);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge iob_clk);
        #1;
    endtask

    // Monitor: compares every expectation scheduled for the cycle just clocked.
    exp_t cur;
    always @(negedge iob_clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            cur = sb.pop_front();
            checks++;
            if (cur.cyc < cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d missed (now %0d)", cur.name, cur.cyc, cyc);
            end else if ({dut_out, sel_active, switch_busy, sel_error, switch_count, fw_in} !==
                         {cur.dout, cur.sel, cur.busy, cur.err, cur.cnt, cur.fwin}) begin
                errors++;
                $display("FAIL %s @%0d: got dout=%h sel=%h busy=%b err=%b cnt=%0d fw_in=%h, want dout=%h sel=%h busy=%b err=%b cnt=%0d fw_in=%h",
                         cur.name, cyc, dut_out, sel_active, switch_busy, sel_error, switch_count, fw_in,
                         cur.dout, cur.sel, cur.busy, cur.err, cur.cnt, cur.fwin);
            end
        end
    end

    int k, r;

    initial begin
        iob_rst_n        = 1'b0;
        fw_dev_id_enable = 4'h0;
        sel_error_clr    = 1'b0;
        fw_out           = {FW3, FW2, FW1, FW0};
        dut_in           = 5'h15;

        // Reset state
        tick(2);
        expect_range("reset", cyc, cyc + 1, DEF, 4'h0, 1'b0, 1'b0, 16'd0, 20'h0);
        tick(2);

        // First ownership: ch1 after a full guard
        iob_rst_n        = 1'b1;
        fw_dev_id_enable = 4'h2;
        k = cyc + 1;
        expect_range("s1_guard",  k + 1,  k + 16, pins(-1), 4'h0, 1'b1, 1'b0, 16'd1 - 16'd1, 20'h0);
        expect_range("s1_active", k + 17, k + 17, pins(-1), 4'h2, 1'b0, 1'b0, 16'd1, fi(1, 5'h15));
        expect_range("s1_drive",  k + 18, k + 20, pins(1),  4'h2, 1'b0, 1'b0, 16'd1, fi(1, 5'h15));
        tick(21);

        // Switch ch1 -> ch2; bxclk pins keep following ch1 throughout
        fw_dev_id_enable = 4'h4;
        k = cyc + 1;
        expect_range("s2_tail",   k + 1,  k + 1,  pins(1),  4'h0, 1'b1, 1'b0, 16'd1, 20'h0);
        expect_range("s2_guard",  k + 2,  k + 16, pins(-1), 4'h0, 1'b1, 1'b0, 16'd1, 20'h0);
        expect_range("s2_active", k + 17, k + 17, pins(-1), 4'h4, 1'b0, 1'b0, 16'd2, fi(2, 5'h15));
        expect_range("s2_drive",  k + 18, k + 19, pins(2),  4'h4, 1'b0, 1'b0, 16'd2, fi(2, 5'h15));
        tick(20);

        // Request ch0, then ch3 mid-guard: guard restarts, ch0 never drives
        fw_dev_id_enable = 4'h1;
        k = cyc + 1;
        expect_range("s3_tail",   k + 1,  k + 1,  pins(2),  4'h0, 1'b1, 1'b0, 16'd2, 20'h0);
        expect_range("s3_guard",  k + 2,  k + 26, pins(-1), 4'h0, 1'b1, 1'b0, 16'd2, 20'h0);
        expect_range("s3_active", k + 27, k + 27, pins(-1), 4'h8, 1'b0, 1'b0, 16'd3, fi(3, 5'h15));
        expect_range("s3_drive",  k + 28, k + 29, pins(3),  4'h8, 1'b0, 1'b0, 16'd3, fi(3, 5'h15));
        tick(10);
        fw_dev_id_enable = 4'h8;
        tick(20);

        // Multi-hot request in ACTIVE, sticky error, clear, set-wins-over-clear
        fw_dev_id_enable = 4'h3;
        k = cyc + 1;
        expect_range("s4_idle",   k + 1, k + 1, pins(3),  4'h0, 1'b0, 1'b1, 16'd3, 20'h0);
        expect_range("s4_sticky", k + 2, k + 3, pins(-1), 4'h0, 1'b0, 1'b1, 16'd3, 20'h0);
        expect_range("s4_clr",    k + 4, k + 5, pins(-1), 4'h0, 1'b0, 1'b0, 16'd3, 20'h0);
        expect_range("s4_setwin", k + 6, k + 7, pins(-1), 4'h0, 1'b0, 1'b1, 16'd3, 20'h0);
        expect_range("s4_clr2",   k + 8, k + 9, pins(-1), 4'h0, 1'b0, 1'b0, 16'd3, 20'h0);
        tick(2);
        fw_dev_id_enable = 4'h0;
        tick(2);
        sel_error_clr = 1'b1;
        tick(1);
        sel_error_clr = 1'b0; fw_dev_id_enable = 4'h3;
        tick(1);
        sel_error_clr = 1'b1; fw_dev_id_enable = 4'h0;
        tick(1);
        sel_error_clr = 1'b0;
        tick(1);
        sel_error_clr = 1'b1;
        tick(1);
        sel_error_clr = 1'b0;
        tick(2);

        // ACTIVE on ch0, input path latency
        fw_dev_id_enable = 4'h1;
        k = cyc + 1;
        expect_range("s5_guard",  k + 1,  k + 16, pins(-1), 4'h0, 1'b1, 1'b0, 16'd3, 20'h0);
        expect_range("s5_active", k + 17, k + 17, pins(-1), 4'h1, 1'b0, 1'b0, 16'd4, fi(0, 5'h15));
        expect_range("s5_old_in", k + 18, k + 20, pins(0),  4'h1, 1'b0, 1'b0, 16'd4, fi(0, 5'h15));
        tick(20);
        dut_in = 5'h0A;
        expect_range("s5_new_in", k + 21, k + 22, pins(0),  4'h1, 1'b0, 1'b0, 16'd4, fi(0, 5'h0A));
        tick(3);

        // Reset mid-guard, then a full guard after release
        fw_dev_id_enable = 4'h2;
        k = cyc + 1;
        expect_range("s6_tail",  k + 1, k + 1, pins(0),  4'h0, 1'b1, 1'b0, 16'd4, 20'h0);
        expect_range("s6_guard", k + 2, k + 3, pins(-1), 4'h0, 1'b1, 1'b0, 16'd4, 20'h0);
        tick(5);
        expect_range("s6_rst", cyc, cyc + 2, DEF, 4'h0, 1'b0, 1'b0, 16'd0, 20'h0);
        iob_rst_n = 1'b0;
        tick(2);
        iob_rst_n = 1'b1;
        r = cyc;
        expect_range("s6_idle",   r + 1,  r + 1,  pins(-1), 4'h0, 1'b0, 1'b0, 16'd0, 20'h0);
        expect_range("s6_reguard",r + 2,  r + 17, pins(-1), 4'h0, 1'b1, 1'b0, 16'd0, 20'h0);
        expect_range("s6_active", r + 18, r + 18, pins(-1), 4'h2, 1'b0, 1'b0, 16'd1, fi(1, 5'h0A));
        expect_range("s6_drive",  r + 19, r + 20, pins(1),  4'h2, 1'b0, 1'b0, 16'd1, fi(1, 5'h0A));
        tick(22);

        for (int w = 0; w < 5 && sb.size() > 0; w++) tick(1);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
